// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter/timer datapath blocks.
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // True when the next count step in direction dir would leave 0..modulus-1.
  function automatic logic limit_hit(input int unsigned q, input dir_t dir,
                                     input int unsigned modulus);
    if (dir == DIR_UP) return (q == modulus - 1);
    else               return (q == 0);
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-count and limit-hit logic for a modulo-N up/down counter.
module mod_n_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 5,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] q,
  input  dir_t             dir,
  output logic [WIDTH-1:0] next_q,
  output logic             hit
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] next_ext;
  logic           unused_next_msb;

  // One spare bit keeps q+1 at the top of the range from silently overflowing.
  assign q_ext = {1'b0, q};
  assign hit   = limit_hit(32'(q), dir, MODULUS);

  always_comb begin
    next_ext = q_ext;
    if (dir == DIR_UP) begin
      if (hit) next_ext = (SATURATE != 0) ? q_ext : '0;
      else     next_ext = q_ext + 1'b1;
    end else begin
      if (hit) next_ext = (SATURATE != 0) ? q_ext : MAX_EXT;
      else     next_ext = q_ext - 1'b1;
    end
  end

  assign next_q          = next_ext[WIDTH-1:0];
  assign unused_next_msb = next_ext[WIDTH];

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clamped load, optional saturation,
// cascadable terminal count and a sticky wrap flag.
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 5,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             reverse,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped
);

  if (MODULUS < 2) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must be at least 2");
  end
  if (((MODULUS - 1) >> WIDTH) != 0) begin : g_bad_width
    $error("mod_n_updown_counter: WIDTH too small for MODULUS");
  end

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

  dir_t             dir;
  logic [WIDTH-1:0] next_q;
  logic             hit;
  logic [WIDTH-1:0] load_clamped;

  assign dir = reverse ? DIR_DOWN : DIR_UP;

  mod_n_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .q      (q),
    .dir    (dir),
    .next_q (next_q),
    .hit    (hit)
  );

  // Clamping on load is what keeps q inside 0..MODULUS-1 at all times.
  assign load_clamped = ({1'b0, load_value} > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_value;
  assign tc           = enable & hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= '0;
      wrapped <= 1'b0;
    end else if (load) begin
      q       <= load_clamped;
      wrapped <= 1'b0;
    end else begin
      if (enable) q <= next_q;
      // A limit event on the same edge as clear_flag keeps the flag set.
      if (enable && hit) wrapped <= 1'b1;
      else if (clear_flag) wrapped <= 1'b0;
    end
  end

endmodule
